// File: rtl/alu.sv
// Registered 32-bit, 8-function ALU with enable/ack handshake and a tri-stateable result bus.
// Latency: 1 clock from a sampled enable edge to result/ack/carry/zero.
// Backpressure: none; every enabled edge is accepted and overwrites the previous result.
//
// Ports:
//   clk      rising-edge clock for all state
//   rst      synchronous, active-high reset (wins over enable)
//   A, B     operands, unsigned, WIDTH bits
//   opcode   function select: 000 A+B, 001 A-B, 010 A+1, 011 A-1,
//                             100 A,   101 ~A,  110 A|B, 111 A&B
//   enable   request a computation on this edge
//   result   registered result, high-Z whenever no valid result is held
//   ack      high while result holds the result of the last enabled edge
//   carry    carry-out (add/inc) or borrow (sub/dec); 0 for logic/pass ops
//   zero     registered result == 0 (meaningful only while ack is high)
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  input  logic             enable,
  output logic [WIDTH-1:0] result,
  output logic             ack,
  output logic             carry,
  output logic             zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_PSA = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  // Operands widened by one bit: the extra MSB of an add is the carry-out, and
  // the extra MSB of a subtract goes to 1 exactly when the unsigned result
  // underflows, i.e. it is the borrow.
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   f_ext;
  logic [WIDTH-1:0] f_val;
  logic             f_carry;
  logic             f_zero;

  assign a_ext = {1'b0, A};
  assign b_ext = {1'b0, B};

  always_comb begin
    f_ext = '0;
    unique case (opcode)
      OP_ADD:  f_ext = a_ext + b_ext;
      OP_SUB:  f_ext = a_ext - b_ext;
      OP_INC:  f_ext = a_ext + ONE_EXT;
      OP_DEC:  f_ext = a_ext - ONE_EXT;
      // Logic and pass functions leave the top bit clear so carry reads 0.
      OP_PSA:  f_ext = {1'b0, A};
      OP_NOT:  f_ext = {1'b0, ~A};
      OP_OR:   f_ext = {1'b0, A | B};
      OP_AND:  f_ext = {1'b0, A & B};
      default: f_ext = '0;
    endcase
  end

  assign f_val   = f_ext[WIDTH-1:0];
  assign f_carry = f_ext[WIDTH];
  assign f_zero  = (f_val == '0);

  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;
  logic             ack_q;
  logic             drive_q;

  // result_q/carry/zero keep their last value on a disabled edge; only the
  // handshake (ack) and bus ownership (drive) fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ack_q    <= 1'b0;
      drive_q  <= 1'b0;
    end else if (enable) begin
      result_q <= f_val;
      carry_q  <= f_carry;
      zero_q   <= f_zero;
      ack_q    <= 1'b1;
      drive_q  <= 1'b1;
    end else begin
      ack_q    <= 1'b0;
      drive_q  <= 1'b0;
    end
  end

  // Bus enable comes only from a flop, so enable never reaches the bus
  // combinationally and the bus is released cleanly on reset.
  assign result = drive_q ? result_q : {WIDTH{1'bz}};
  assign ack    = ack_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed spec cases with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu;

  localparam int W = 32;
  localparam logic [W-1:0] ALL1 = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   opcode = 3'b000;
  logic         enable = 1'b0;
  wire  [W-1:0] result;
  wire          ack;
  wire          carry;
  wire          zero;

  int checks = 0;
  int errors = 0;

  alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .opcode(opcode), .enable(enable),
    .result(result), .ack(ack), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_q = '0;
  logic         m_c = 1'b0;
  logic         m_z = 1'b0;
  logic         m_ack = 1'b0;
  logic         m_valid = 1'b0;

  task automatic ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2:0] op,
                        output logic [W-1:0] r, output logic c);
    logic [63:0] wide;
    r = '0;
    c = 1'b0;
    case (op)
      3'd0: begin wide = 64'(x) + 64'(y); r = wide[W-1:0]; c = (wide > 64'(ALL1)); end
      3'd1: begin r = x - y; c = (x < y); end
      3'd2: begin r = x + 1; c = (x == ALL1); end
      3'd3: begin r = x - 1; c = (x == '0); end
      3'd4: r = x;
      3'd5: r = ~x;
      3'd6: r = x | y;
      default: r = x & y;
    endcase
  endtask

  always @(posedge clk) begin
    logic [W-1:0] r;
    logic         c;
    if (rst) begin
      m_q <= '0; m_c <= 1'b0; m_z <= 1'b0; m_ack <= 1'b0; m_valid <= 1'b1;
    end else if (enable) begin
      ref_op(a, b, opcode, r, c);
      m_q <= r; m_c <= c; m_z <= (r == '0); m_ack <= 1'b1;
    end else begin
      m_ack <= 1'b0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // A released bus reads as z on 4-state simulators and as 0 on 2-state ones.
  task automatic check_hiz(input string name);
    checks++;
    if (!((result === {W{1'bz}}) || (result === {W{1'b0}}))) begin
      errors++;
      $display("FAIL %s got=%h exp=zzzzzzzz at %0t", name, result, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_ack", {31'b0, ack}, {31'b0, m_ack});
      check("model_carry", {31'b0, carry}, {31'b0, m_c});
      check("model_zero", {31'b0, zero}, {31'b0, m_z});
      if (m_ack) check("model_result", result, m_q);
      else       check_hiz("model_result_hiz");
    end
  end

  // Drive for one edge, then return at the following falling edge.
  task automatic apply(input logic r, input logic en, input logic [2:0] op,
                       input logic [W-1:0] x, input logic [W-1:0] y);
    rst = r; enable = en; opcode = op; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] exp_tbl [8];
  logic [W-1:0] rx, ry;

  initial begin
    exp_tbl[0] = 32'd15; exp_tbl[1] = 32'd5;  exp_tbl[2] = 32'd11; exp_tbl[3] = 32'd9;
    exp_tbl[4] = 32'd10; exp_tbl[5] = 32'hFFFF_FFF5; exp_tbl[6] = 32'd15; exp_tbl[7] = 32'd0;

    @(negedge clk);
    // 1) reset
    apply(1'b1, 1'b1, 3'd0, 32'd10, 32'd5);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check_hiz("rst_result");
    check("rst_carry", {31'b0, carry}, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);

    // 2) all opcodes back to back, A=10 B=5
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 3'(i), 32'd10, 32'd5);
      check($sformatf("op%0d_result", i), result, exp_tbl[i]);
      check($sformatf("op%0d_ack", i), {31'b0, ack}, 32'd1);
      check($sformatf("op%0d_zero", i), {31'b0, zero}, (i == 7) ? 32'd1 : 32'd0);
      check($sformatf("op%0d_carry", i), {31'b0, carry}, 32'd0);
    end

    // 3) disable then re-enable
    apply(1'b0, 1'b0, 3'd0, 32'd10, 32'd5);
    check_hiz("dis_result");
    check("dis_ack", {31'b0, ack}, 32'd0);
    apply(1'b0, 1'b1, 3'd0, 32'd10, 32'd5);
    check("reen_result", result, 32'd15);
    check("reen_ack", {31'b0, ack}, 32'd1);

    // 4) wrap-around
    apply(1'b0, 1'b1, 3'd2, ALL1, 32'd0);
    check("inc_wrap_result", result, 32'd0);
    check("inc_wrap_carry", {31'b0, carry}, 32'd1);
    check("inc_wrap_zero", {31'b0, zero}, 32'd1);
    apply(1'b0, 1'b1, 3'd3, 32'd0, 32'd0);
    check("dec_wrap_result", result, ALL1);
    check("dec_wrap_carry", {31'b0, carry}, 32'd1);
    check("dec_wrap_zero", {31'b0, zero}, 32'd0);
    apply(1'b0, 1'b1, 3'd0, ALL1, 32'd1);
    check("add_wrap_result", result, 32'd0);
    check("add_wrap_carry", {31'b0, carry}, 32'd1);

    // 5) borrow
    apply(1'b0, 1'b1, 3'd1, 32'd5, 32'd10);
    check("sub_borrow_result", result, 32'hFFFF_FFFB);
    check("sub_borrow_carry", {31'b0, carry}, 32'd1);
    apply(1'b0, 1'b1, 3'd1, 32'd10, 32'd5);
    check("sub_noborrow_carry", {31'b0, carry}, 32'd0);
    // logic op after a carry must clear carry
    apply(1'b0, 1'b1, 3'd2, ALL1, 32'd0);
    apply(1'b0, 1'b1, 3'd6, 32'hF0, 32'h0F);
    check("or_result", result, 32'hFF);
    check("or_carry_clear", {31'b0, carry}, 32'd0);

    // 6) reset mid-stream, then recover
    apply(1'b0, 1'b1, 3'd0, 32'd1, 32'd2);
    apply(1'b1, 1'b1, 3'd0, 32'd3, 32'd4);
    check("midrst_ack", {31'b0, ack}, 32'd0);
    check_hiz("midrst_result");
    apply(1'b0, 1'b1, 3'd0, 32'd3, 32'd4);
    check("postrst_result", result, 32'd7);
    check("postrst_ack", {31'b0, ack}, 32'd1);

    // randomized traffic, checked by the model compare process
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0: rx = '0;
        1: rx = ALL1;
        default: rx = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: ry = '0;
        1: ry = rx;
        default: ry = $urandom;
      endcase
      apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)), rx, ry);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
